// File: rtl/execute_stack_seq_if.sv
// Request/response bundle for the stack address sequencer.
// The master side issues the sequence; the slave side is the sequencer itself.
interface execute_stack_seq_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             start;
  logic             dir_pop;
  logic             operand_16bit;
  logic             stack_32bit;
  logic [31:0]      esp_in;
  logic [CNT_W-1:0] word_count;
  logic [15:0]      imm16;
  logic             offset_ready;
  logic             abort;
  logic             busy;
  logic             offset_valid;
  logic [31:0]      stack_offset;
  logic             offset_last;
  logic [CNT_W-1:0] word_index;
  logic             done;
  logic [31:0]      final_esp;

  modport master (
    output start, dir_pop, operand_16bit, stack_32bit, esp_in, word_count, imm16,
           offset_ready, abort,
    input  busy, offset_valid, stack_offset, offset_last, word_index, done, final_esp
  );

  modport slave (
    input  start, dir_pop, operand_16bit, stack_32bit, esp_in, word_count, imm16,
           offset_ready, abort,
    output busy, offset_valid, stack_offset, offset_last, word_index, done, final_esp
  );
endinterface

// File: rtl/execute_stack_seq.sv
// Generates the per-word stack addresses for multi-word PUSH/POP/RET sequences
// and the resulting ESP, one word per cycle under a valid/ready handshake.
module execute_stack_seq #(
  parameter int unsigned MAX_WORDS = 8,
  parameter int unsigned CNT_W     = 4
) (
  input logic                clk,
  input logic                rst_n,
  execute_stack_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic             pop_q, pop_d;
  logic             half_q, half_d;
  logic             s32_q, s32_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      imm_q, imm_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [31:0]      off_q, off_d;
  logic [31:0]      final_q, final_d;

  logic [CNT_W-1:0] cnt_clamp;
  logic [31:0]      size_new, size_cur;
  logic             is_last;

  // 16-bit stacks wrap SP within 64K and keep the upper half of ESP untouched.
  function automatic logic [31:0] mask_sp(input logic s32, input logic [31:0] base,
                                          input logic [31:0] res);
    return s32 ? res : {base[31:16], res[15:0]};
  endfunction

  always_comb begin
    cnt_clamp = (bus.word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : bus.word_count;
    size_new  = bus.operand_16bit ? 32'd2 : 32'd4;
    size_cur  = half_q ? 32'd2 : 32'd4;
    is_last   = (idx_q == count_q - CNT_W'(1));

    state_d = state_q;
    base_d  = base_q;
    pop_d   = pop_q;
    half_d  = half_q;
    s32_d   = s32_q;
    count_d = count_q;
    imm_d   = imm_q;
    idx_d   = idx_q;
    off_d   = off_q;
    final_d = final_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.esp_in;
          pop_d   = bus.dir_pop;
          half_d  = bus.operand_16bit;
          s32_d   = bus.stack_32bit;
          count_d = cnt_clamp;
          imm_d   = bus.imm16;
          idx_d   = '0;
          if (cnt_clamp == '0) begin
            final_d = mask_sp(bus.stack_32bit, bus.esp_in,
                              bus.esp_in + (bus.dir_pop ? {16'h0, bus.imm16} : 32'h0));
            state_d = DONE;
          end else begin
            off_d   = mask_sp(bus.stack_32bit, bus.esp_in,
                              bus.dir_pop ? bus.esp_in : bus.esp_in - size_new);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.offset_ready) begin
          if (is_last) begin
            // Push ends at the last written slot; pop steps past it and releases imm16.
            final_d = pop_q ? mask_sp(s32_q, base_q, off_q + size_cur + {16'h0, imm_q}) : off_q;
            state_d = DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1);
            off_d = mask_sp(s32_q, base_q, pop_q ? off_q + size_cur : off_q - size_cur);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = idx_q;
      off_d   = off_q;
      final_d = final_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      pop_q   <= 1'b0;
      half_q  <= 1'b0;
      s32_q   <= 1'b0;
      count_q <= '0;
      imm_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      final_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pop_q   <= pop_d;
      half_q  <= half_d;
      s32_q   <= s32_d;
      count_q <= count_d;
      imm_q   <= imm_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      final_q <= final_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.offset_valid = (state_q == RUN);
  assign bus.done         = (state_q == DONE);
  assign bus.offset_last  = (state_q == RUN) && is_last;
  assign bus.stack_offset = off_q;
  assign bus.word_index   = idx_q;
  assign bus.final_esp    = final_q;

endmodule

// File: tb/tb_execute_stack_seq.sv
// Directed bench for execute_stack_seq: a vector table of complete sequences
// plus hand-written backpressure, abort and mid-sequence reset scenarios.
module tb_execute_stack_seq;

  localparam int unsigned MAX_WORDS = 8;
  localparam int unsigned CNT_W     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_stack_seq_if #(.CNT_W(CNT_W)) ifc ();

  execute_stack_seq #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  typedef struct {
    logic        pop;
    logic        h16;
    logic        s32;
    logic [31:0] esp;
    logic [3:0]  cnt;
    logic [15:0] imm;
    logic [31:0] first;
    logic [31:0] fin;
    int          n;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;

  always @(negedge clk) begin
    if (ifc.done) done_cnt <= done_cnt + 1;
    if (ifc.offset_valid && ifc.offset_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] sz, e;
    sz = v.h16 ? 32'd2 : 32'd4;
    ifc.start         = 1'b1;
    ifc.dir_pop       = v.pop;
    ifc.operand_16bit = v.h16;
    ifc.stack_32bit   = v.s32;
    ifc.esp_in        = v.esp;
    ifc.word_count    = v.cnt;
    ifc.imm16         = v.imm;
    ifc.offset_ready  = 1'b1;
    step();
    ifc.start = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      e = v.pop ? v.first + sz * k : v.first - sz * k;
      if (!v.s32) e = {v.esp[31:16], e[15:0]};
      chk("valid", 32'(ifc.offset_valid), 32'd1);
      chk("offset", ifc.stack_offset, e);
      chk("index", 32'(ifc.word_index), k);
      chk("last", 32'(ifc.offset_last), 32'(k == v.n - 1));
      chk("done_early", 32'(ifc.done), 32'd0);
      step();
    end
    chk("done", 32'(ifc.done), 32'd1);
    chk("valid_in_done", 32'(ifc.offset_valid), 32'd0);
    chk("final_esp", ifc.final_esp, v.fin);
    step();
    chk("done_one_cycle", 32'(ifc.done), 32'd0);
    chk("busy_after", 32'(ifc.busy), 32'd0);
    chk("final_held", ifc.final_esp, v.fin);
  endtask

  vec_t vecs[8];
  int   d0, a0;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_1000, 4'd3,  16'h0,  32'h0000_0FFC, 32'h0000_0FF4, 3};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'hABCD_FFFC, 4'd3,  16'h4,  32'hABCD_FFFC, 32'hABCD_0006, 3};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h1234_0002, 4'd2,  16'h0,  32'h1234_0000, 32'h1234_FFFE, 2};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_FFFC, 4'd2,  16'h10, 32'h0000_FFFC, 32'h0001_0014, 2};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 4'd11, 16'h0,  32'h0000_00FC, 32'h0000_00E0, 8};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 4'd0,  16'h8,  32'h0,         32'h0000_0208, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h5678_0000, 4'd0,  16'h55, 32'h0,         32'h5678_0000, 0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'd1,  16'h2,  32'hFFFF_FFFE, 32'h0000_0002, 1};

    ifc.start = 1'b0; ifc.dir_pop = 1'b0; ifc.operand_16bit = 1'b0; ifc.stack_32bit = 1'b1;
    ifc.esp_in = '0; ifc.word_count = '0; ifc.imm16 = '0; ifc.offset_ready = 1'b0;
    ifc.abort = 1'b0;

    step();
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_valid", 32'(ifc.offset_valid), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_offset", ifc.stack_offset, 32'd0);
    chk("rst_final", ifc.final_esp, 32'd0);
    chk("rst_index", 32'(ifc.word_index), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: 2-word push with ready pattern 0,1,0,0,1.
    d0 = done_cnt; a0 = acc_cnt;
    ifc.start = 1'b1; ifc.dir_pop = 1'b0; ifc.operand_16bit = 1'b0; ifc.stack_32bit = 1'b1;
    ifc.esp_in = 32'h1000; ifc.word_count = 4'd2; ifc.imm16 = '0; ifc.offset_ready = 1'b0;
    step();
    ifc.start = 1'b0;
    chk("bp_off0", ifc.stack_offset, 32'h0FFC);
    step();
    chk("bp_hold_off", ifc.stack_offset, 32'h0FFC);
    chk("bp_hold_idx", 32'(ifc.word_index), 32'd0);
    ifc.offset_ready = 1'b1;
    step();
    chk("bp_off1", ifc.stack_offset, 32'h0FF8);
    chk("bp_last", 32'(ifc.offset_last), 32'd1);
    ifc.offset_ready = 1'b0;
    step();
    step();
    chk("bp_hold2_off", ifc.stack_offset, 32'h0FF8);
    chk("bp_hold2_idx", 32'(ifc.word_index), 32'd1);
    chk("bp_hold2_valid", 32'(ifc.offset_valid), 32'd1);
    ifc.offset_ready = 1'b1;
    step();
    chk("bp_done", 32'(ifc.done), 32'd1);
    chk("bp_final", ifc.final_esp, 32'h0FF8);
    step();
    step();
    chk("bp_acc_count", acc_cnt - a0, 32'd2);
    chk("bp_done_count", done_cnt - d0, 32'd1);

    // Abort on the second word of a 4-word push with start and ready also high.
    d0 = done_cnt;
    ifc.start = 1'b1; ifc.esp_in = 32'h2000; ifc.word_count = 4'd4; ifc.offset_ready = 1'b1;
    step();
    ifc.start = 1'b0;
    chk("ab_off0", ifc.stack_offset, 32'h1FFC);
    step();
    chk("ab_off1", ifc.stack_offset, 32'h1FF8);
    ifc.abort = 1'b1; ifc.start = 1'b1;
    step();
    ifc.abort = 1'b0; ifc.start = 1'b0;
    chk("ab_busy", 32'(ifc.busy), 32'd0);
    chk("ab_valid", 32'(ifc.offset_valid), 32'd0);
    chk("ab_final", ifc.final_esp, 32'h0FF8);
    step();
    chk("ab_idle", 32'(ifc.busy), 32'd0);
    step();
    chk("ab_no_done", done_cnt - d0, 32'd0);

    // Asynchronous reset during word 1 of a 3-word push.
    d0 = done_cnt;
    ifc.start = 1'b1; ifc.esp_in = 32'h3000; ifc.word_count = 4'd3;
    step();
    ifc.start = 1'b0;
    step();
    chk("rr_word1", 32'(ifc.word_index), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rr_busy", 32'(ifc.busy), 32'd0);
    chk("rr_valid", 32'(ifc.offset_valid), 32'd0);
    chk("rr_offset", ifc.stack_offset, 32'd0);
    chk("rr_index", 32'(ifc.word_index), 32'd0);
    chk("rr_final", ifc.final_esp, 32'd0);
    chk("rr_last", 32'(ifc.offset_last), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rr_no_done", done_cnt - d0, 32'd0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_stack_seq.md
EXECUTE_STACK_SEQ -- requirements
Module: execute_stack_seq

Interface
REQ-001 Parameter MAX_WORDS, default 8, gives the maximum number of stack words per sequence (range 1..15).
REQ-002 Parameter CNT_W, default 4, gives the width of the word-count and index fields; it SHALL be at least clog2(MAX_WORDS+1).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port start  input  1  requests a new sequence; it is sampled only in IDLE.
REQ-006 Port dir_pop  input  1  selects the direction: 0 = push (decrementing), 1 = pop (incrementing).
REQ-007 Port operand_16bit  input  1  selects the word size: 1 = 2 bytes, 0 = 4 bytes.
REQ-008 Port stack_32bit  input  1  carries the SS descriptor D/B bit: 1 = 32-bit ESP arithmetic, 0 = 16-bit SP arithmetic.
REQ-009 Port esp_in  input  32  is the starting ESP.
REQ-010 Port word_count  input  CNT_W  is the number of words in the sequence.
REQ-011 Port imm16  input  16  is the release adjustment added after the last pop (RET imm16); it is ignored for push.
REQ-012 Port offset_ready  input  1  is the consumer acceptance of the current offset.
REQ-013 Port abort  input  1  cancels the sequence (exception or pipeline flush).
REQ-014 Port busy  output  1  is high whenever the state is not IDLE.
REQ-015 Port offset_valid  output  1  means stack_offset holds a valid word address.
REQ-016 Port stack_offset  output  32  is the address of the current word.
REQ-017 Port offset_last  output  1  marks the final word of the sequence.
REQ-018 Port word_index  output  CNT_W  is the index of the current word, starting at 0.
REQ-019 Port done  output  1  is a one-cycle completion pulse.
REQ-020 Port final_esp  output  32  is the resulting ESP; it is valid while done is high and held afterwards.

Function
REQ-021 The block SHALL have three states: IDLE, RUN and DONE.
REQ-022 In IDLE, start=1 with word_count in 1..MAX_WORDS SHALL latch esp_in, dir_pop, the word size, stack_32bit, word_count and imm16, and SHALL move to RUN on the next cycle.
REQ-023 In IDLE, start=1 with word_count=0 SHALL go directly to DONE with final_esp = esp_in masked per REQ-027 (plus imm16 if dir_pop=1).
REQ-024 In IDLE, start=1 with word_count > MAX_WORDS SHALL be clamped to MAX_WORDS.
REQ-025 In RUN, offset_valid SHALL be 1 and stack_offset SHALL be:
  - push: base - size*(k+1)
  - pop: base + size*k
  where k = word_index and size is 2 or 4.
REQ-026 The offset SHALL be registered; the first offset SHALL appear in the cycle after start.
REQ-027 All arithmetic SHALL be done at 32 bits. When stack_32bit=0, outputs SHALL be {base[31:16], result[15:0]}, i.e. SP wraps modulo 64K and the upper half is preserved.
REQ-028 In RUN, offset_valid=1 with offset_ready=1 SHALL increment word_index on the next edge. With offset_ready=0, all outputs SHALL hold.
REQ-029 offset_last SHALL equal offset_valid AND (word_index == count-1).
REQ-030 Acceptance of the last word SHALL move the block to DONE and register final_esp:
  - push: base - size*count
  - pop: base + size*count + imm16
  Both are masked per REQ-027.
REQ-031 DONE SHALL last exactly one cycle, with done=1 and offset_valid=0, and SHALL then return to IDLE; start is ignored while in DONE.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 abort=1 in any state SHALL force IDLE on the next edge. done SHALL not assert, final_esp SHALL keep its previous value, and abort SHALL take priority over both start and offset_ready in the same cycle.
REQ-034 The block SHALL sustain one word per cycle when offset_ready is held high; an N-word sequence SHALL take N+2 cycles from start to the done pulse.

Reset
REQ-035 While rst_n=0, the state SHALL be IDLE and busy, offset_valid, offset_last and done SHALL be 0.
REQ-036 While rst_n=0, stack_offset, final_esp and word_index SHALL be 0, and all latched fields SHALL be 0.
REQ-037 Reset asserted mid-sequence SHALL take effect immediately (asynchronously) with no done pulse; after release, the first start SHALL behave as from power-up.

Verification
REQ-038 Push, 32-bit: esp_in=0x00001000, 32-bit words, stack_32bit=1, count=3, ready held high -> offsets 0x0FFC, 0x0FF8, 0x0FF4 on consecutive cycles, last on the third, done next with final_esp=0x00000FF4.
REQ-039 Pop, 16-bit, with imm and wrap: esp_in=0xABCDFFFC, 16-bit words, stack_32bit=0, count=3, imm16=4 -> offsets 0xABCDFFFC, 0xABCDFFFE, 0xABCD0000; final_esp=0xABCD0006.
REQ-040 Backpressure: ready toggled 0,1,0,0,1 during a 2-word push -> offset and word_index held while ready=0, exactly 2 acceptances, and a single done pulse.
REQ-041 Abort: abort on the second word of a 4-word push, with start and ready also high -> IDLE next cycle, no done, final_esp unchanged, start ignored that cycle.
REQ-042 Count edges: count=0 with esp_in=0x200 and pop imm16=8 -> done one cycle after start, final_esp=0x208, no offset_valid; count=MAX_WORDS+3 -> exactly MAX_WORDS offsets.
REQ-043 Reset mid-RUN: rst_n low for one cycle during word 1 -> all outputs 0 immediately, no done; a subsequent start runs normally.
